// File: rtl/adder_tree_pipe.sv
// Fully pipelined binary adder tree: 2**LEVELS operands summed with one register per level.
// Optional output accumulator enabled by defining ADDER_TREE_PIPE_ACCUM_EN.
module adder_tree_pipe #(
  parameter int unsigned WIDTH  = 13,
  parameter int unsigned LEVELS = 3,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [(WIDTH<<LEVELS)-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH+LEVELS-1:0]      out_sum,
  output logic                         busy
`ifdef ADDER_TREE_PIPE_ACCUM_EN
  ,
  input  logic                         acc_clr,
  output logic [ACC_W-1:0]             acc_sum,
  output logic [15:0]                  acc_cnt
`endif
);

  localparam int unsigned N_IN  = 1 << LEVELS;
  localparam int unsigned OUT_W = WIDTH + LEVELS;
  localparam int unsigned CNT_W = 16;

  if (LEVELS < 1 || LEVELS > 6) begin : g_bad_levels
    $error("adder_tree_pipe: LEVELS must be 1..6");
  end
  if (ACC_W < OUT_W) begin : g_bad_acc_w
    $error("adder_tree_pipe: ACC_W must be >= WIDTH+LEVELS");
  end

  // Global stall: every stage moves together or nothing moves.
  logic adv;
  logic [LEVELS:0] stage_vld;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned N = N_IN >> l;
    localparam int unsigned W = WIDTH + l;

    logic v;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= 1'b0;
      end else if (adv) begin
        if (l == 0) v <= in_valid;
        else        v <= g_lvl[(l == 0) ? 0 : l-1].v;
      end
    end

    assign stage_vld[l] = v;

    for (genvar k = 0; k < N; k++) begin : g_e
      logic [W-1:0] q;

      if (l == 0) begin : g_in
        always_ff @(posedge clk or posedge rst) begin
          if (rst)      q <= '0;
          else if (adv) q <= in_data[k*WIDTH +: WIDTH];
        end
      end else begin : g_add
        logic [W-2:0] a;
        logic [W-2:0] b;
        logic [W-1:0] a_ext;
        logic [W-1:0] b_ext;

        assign a = g_lvl[l-1].g_e[2*k].q;
        assign b = g_lvl[l-1].g_e[2*k+1].q;
        // One guard bit per level keeps the sum exact.
        assign a_ext = {(SIGNED != 0) ? a[W-2] : 1'b0, a};
        assign b_ext = {(SIGNED != 0) ? b[W-2] : 1'b0, b};

        always_ff @(posedge clk or posedge rst) begin
          if (rst)      q <= '0;
          else if (adv) q <= a_ext + b_ext;
        end
      end
    end
  end

  assign out_valid = g_lvl[LEVELS].v;
  assign out_sum   = g_lvl[LEVELS].g_e[0].q;
  assign busy      = |stage_vld;

`ifdef ADDER_TREE_PIPE_ACCUM_EN
  logic [ACC_W-1:0] acc_ext;

  always_comb begin
    acc_ext              = {ACC_W{(SIGNED != 0) && out_sum[OUT_W-1]}};
    acc_ext[OUT_W-1:0]   = out_sum;
  end

  // Clear wins over a result draining in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (acc_clr) begin
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (out_valid && out_ready) begin
      acc_sum <= acc_sum + acc_ext;
      if (acc_cnt != {CNT_W{1'b1}}) acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Randomized self-checking bench for adder_tree_pipe (unsigned and signed instances).
// Accumulator checks are compiled in when ADDER_TREE_PIPE_ACCUM_EN is defined.
module tb_adder_tree_pipe;

  localparam int unsigned WIDTH  = 13;
  localparam int unsigned LEVELS = 3;
  localparam int unsigned N_IN   = 8;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned DW     = WIDTH * N_IN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, out_valid, out_ready, busy;
  logic [DW-1:0]    in_data;
  logic [OUT_W-1:0] out_sum;

  logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [DW-1:0]    s_in_data;
  logic [OUT_W-1:0] s_out_sum;

`ifdef ADDER_TREE_PIPE_ACCUM_EN
  logic        acc_clr, s_acc_clr;
  logic [31:0] acc_sum, s_acc_sum;
  logic [15:0] acc_cnt, s_acc_cnt;
`endif

  adder_tree_pipe #(.WIDTH(WIDTH), .LEVELS(LEVELS), .SIGNED(0), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
`ifdef ADDER_TREE_PIPE_ACCUM_EN
    , .acc_clr(acc_clr), .acc_sum(acc_sum), .acc_cnt(acc_cnt)
`endif
  );

  adder_tree_pipe #(.WIDTH(WIDTH), .LEVELS(LEVELS), .SIGNED(1), .ACC_W(32)) u_sgn (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum), .busy(s_busy)
`ifdef ADDER_TREE_PIPE_ACCUM_EN
    , .acc_clr(s_acc_clr), .acc_sum(s_acc_sum), .acc_cnt(s_acc_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int first_out = 0;
  int last_out = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic             hold_prev = 1'b0;
  logic [OUT_W-1:0] prev_sum = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: plain integer sum of the operands, interpreted per signedness.
  function automatic logic [OUT_W-1:0] ref_sum(input logic [DW-1:0] v, input bit sgn);
    int s = 0;
    for (int k = 0; k < int'(N_IN); k++) begin
      int x = int'(v[k*WIDTH +: WIDTH]);
      if (sgn && x >= 4096) x -= 8192;
      s += x;
    end
    return OUT_W'(s);
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v = '0;
    for (int k = 0; k < int'(N_IN); k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  function automatic logic [DW-1:0] fill_vec(input logic [WIDTH-1:0] even, input logic [WIDTH-1:0] odd);
    logic [DW-1:0] v = '0;
    for (int k = 0; k < int'(N_IN); k++) v[k*WIDTH +: WIDTH] = (k % 2 == 0) ? even : odd;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard on the unsigned instance: order, values, stall hold, backpressure.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("hold_sum", out_sum, prev_sum);
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else check("stream_sum", out_sum, exp_q.pop_front());
        n_out++;
        if (n_out == 1) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sum(in_data, 1'b0));
        n_in++;
      end
      hold_prev = out_valid && !out_ready;
      prev_sum  = out_sum;
    end
  end

  // Latency counts edges starting with the accepting edge.
  task automatic latency_run(input string tag, input logic [DW-1:0] v, input logic [OUT_W-1:0] exp);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = v;
    check({tag, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, LEVELS + 1);
    check({tag, "_sum"}, out_sum, exp);
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int n, input int stall_at, input int stall_len);
    int  sent = 0;
    int  c = 0;
    bit  acc;
    n_in = 0;
    n_out = 0;
    in_valid = 1'b1;
    in_data  = rand_vec();
    while (sent < n && c < 500) begin
      out_ready = !(c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      acc = in_ready;
      if (acc) sent++;
      @(posedge clk); #1;
      c++;
      if (sent == n) in_valid = 1'b0;
      else if (acc)  in_data = rand_vec();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (n_out < n && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("stream_in_count", n_in, n);
    check("stream_out_count", n_out, n);
    check("stream_queue_empty", exp_q.size(), 0);
  endtask

  task automatic s_run(input string tag, input logic [DW-1:0] v, input logic [OUT_W-1:0] exp);
    check({tag, "_ready"}, s_in_ready, 1);
    s_in_valid = 1'b1;
    s_in_data  = v;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    repeat (LEVELS) @(posedge clk);
    #1;
    check({tag, "_valid"}, s_out_valid, 1);
    check({tag, "_sum"}, s_out_sum, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    s_out_ready = 1'b1;
`ifdef ADDER_TREE_PIPE_ACCUM_EN
    acc_clr   = 1'b0;
    s_acc_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Maximum unsigned operands.
    latency_run("max_unsigned", fill_vec(13'h1FFF, 13'h1FFF), 16'd65528);

    // Signed corner values and random signed vectors.
    s_run("sgn_min", fill_vec(13'h1000, 13'h1000), 16'h8000);
    s_run("sgn_pairs", fill_vec(13'h0FFF, 13'h1000), 16'hFFFC);
    for (int i = 0; i < 4; i++) begin
      v = rand_vec();
      s_run("sgn_rand", v, ref_sum(v, 1'b1));
    end
    check("sgn_idle_busy", s_busy, 0);

    // Back-to-back stream must drain on consecutive cycles.
    run_stream(20, 1000, 0);
    check("stream_consecutive", last_out - first_out, 19);
    check("stream_idle_busy", busy, 0);

    // Backpressure with a full pipe.
    run_stream(20, 8, 6);

    // Reset with three transactions in flight.
    n_out = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = rand_vec();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum", out_sum, 0);
    check("mid_rst_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_stale", n_out, 0);
    v = '0;
    for (int k = 0; k < int'(N_IN); k++) v[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
    latency_run("post_rst", v, 16'd36);

`ifdef ADDER_TREE_PIPE_ACCUM_EN
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("acc_clr_sum", acc_sum, 0);
    check("acc_clr_cnt", acc_cnt, 0);
    v = '0;
    v[WIDTH-1:0] = WIDTH'(100);
    in_data  = v;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("acc_five_sum", acc_sum, 500);
    check("acc_five_cnt", acc_cnt, 5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      @(posedge clk); #1;
    end
    check("acc_sixth_valid", out_valid, 1);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("acc_drop_sum", acc_sum, 0);
    check("acc_drop_cnt", acc_cnt, 0);
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
